// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite definitions used by the read and write slaves.
// Holds the read FSM state type and the response codes.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    RESP
  } axil_rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_read_slave.sv
// AXI-lite read slave: one transaction at a time, fronting a
// register block that returns data one cycle after rd_en.
module axi_lite_read_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  axil_rd_state_e state;
  axil_rd_state_e state_nxt;

  logic                  ar_hs;
  logic                  addr_ok;
  logic [ADDR_WIDTH-1:0] word_idx;

  assign word_idx = s_axi_araddr >> 2;
  assign addr_ok  = (s_axi_araddr[1:0] == 2'b00) &&
                    (32'(word_idx) < 32'(NUM_REGS));
  assign ar_hs    = s_axi_arvalid && s_axi_arready;

  assign s_axi_arready = (state == IDLE);
  assign s_axi_rvalid  = (state == RESP);
  assign rd_en         = (state == READ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ar_hs) begin
          state_nxt = addr_ok ? READ : RESP;
        end
      end
      READ: state_nxt = WAIT;
      WAIT: state_nxt = RESP;
      RESP: begin
        if (s_axi_rready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response fields only change outside RESP, so they hold under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr     <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        rd_addr <= s_axi_araddr;
        if (!addr_ok) begin
          s_axi_rdata <= '0;
          s_axi_rresp <= RESP_SLVERR;
        end
      end
      if (state == WAIT) begin
        s_axi_rdata <= rd_data;
        s_axi_rresp <= RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_read_slave.sv
// Scoreboard bench for axi_lite_read_slave with a register
// block model and a second instance configured with two registers.
module tb_axi_lite_read_slave;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;

  logic [AW-1:0] b_araddr = '0;
  logic          b_arvalid = 1'b0;
  logic          b_arready;
  logic [DW-1:0] b_rdata;
  logic [1:0]    b_rresp;
  logic          b_rvalid;
  logic          b_rready = 1'b0;
  logic          b_rd_en;
  logic [AW-1:0] b_rd_addr;
  logic [DW-1:0] b_rd_data = 32'h1234_5678;

  always #5 clk = ~clk;

  axi_lite_read_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
    .s_axi_rready(rready), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  axi_lite_read_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(2)
  ) dut_b (
    .clk(clk), .rst(rst),
    .s_axi_araddr(b_araddr), .s_axi_arvalid(b_arvalid),
    .s_axi_arready(b_arready), .s_axi_rdata(b_rdata),
    .s_axi_rresp(b_rresp), .s_axi_rvalid(b_rvalid),
    .s_axi_rready(b_rready), .rd_en(b_rd_en),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          due;
  } exp_t;

  typedef struct {
    logic [3:0] addr;
    int         due;
  } rdx_t;

  exp_t        exp_q[$];
  rdx_t        rd_q[$];
  logic [31:0] mem[NR];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  bit mon_en = 0;
  bit bp_req = 0;
  bit bp_used = 0;
  bit in_flight = 0;
  bit resp_active = 0;
  int hold = 0;
  int stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic bit is_legal(input int a, input int n);
    return (a % 4 == 0) && (a / 4 < n);
  endfunction

  // Register block: data for the strobed word appears the cycle after.
  initial begin
    bit            en_q;
    logic [AW-1:0] a_q;
    forever begin
      @(negedge clk);
      en_q = rd_en;
      a_q  = rd_addr;
      @(posedge clk);
      #1;
      rd_data = en_q ? mem[a_q[3:2]] : $urandom;
    end
  end

  // Monitor: checks every negedge against the scoreboard.
  initial begin
    exp_t cur;
    rdx_t r;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_flight   = 0;
        resp_active = 0;
        continue;
      end
      chk("arready", 32'(arready), 32'(!in_flight));
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          chk("rd_en_spurious", 32'(rd_en), 32'd0);
        end else begin
          r = rd_q.pop_front();
          chk("rd_addr", 32'(rd_addr), 32'(r.addr));
          chk("rd_en_cycle", cyc, r.due);
        end
      end
      if (rvalid) begin
        if (!resp_active) begin
          if (exp_q.size() == 0) begin
            chk("rvalid_spurious", 32'(rvalid), 32'd0);
          end else begin
            cur = exp_q.pop_front();
            chk("latency", cyc, cur.due);
            chk("rdata", rdata, cur.data);
            chk("rresp", 32'(rresp), 32'(cur.resp));
            resp_active = 1;
            stalls = 0;
          end
        end else begin
          chk("rdata_stable", rdata, cur.data);
          chk("rresp_stable", 32'(rresp), 32'(cur.resp));
        end
        if (rready) begin
          if (bp_used) begin
            chk("bp_stalls", stalls, 5);
            bp_used = 0;
          end
          resp_active = 0;
          in_flight = 0;
        end else begin
          stalls++;
        end
      end
      if (arvalid && arready) in_flight = 1;
    end
  end

  // R channel ready: random, or a 5-cycle stall when requested.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        rready = 1'b0;
      end else begin
        if (bp_req && rvalid && !resp_active) begin
          hold    = 5;
          bp_req  = 0;
          bp_used = 1;
        end
        if (hold > 0) begin
          rready = 1'b0;
          hold--;
        end else if (bp_used) begin
          rready = 1'b1;
        end else begin
          rready = ($urandom_range(0, 3) != 0);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] a,
                       input bit push,
                       input bit keep);
    bit   ok;
    logic legal;
    ok = 0;
    @(posedge clk);
    #1;
    arvalid = 1'b1;
    araddr  = a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arready) begin
        ok = 1;
        break;
      end
    end
    chk("ar_accept", 32'(ok), 32'd1);
    if (ok && push) begin
      legal = is_legal(int'(a), NR);
      exp_q.push_back('{
        data: legal ? mem[a[3:2]] : 32'h0,
        resp: legal ? 2'b00 : 2'b10,
        due:  cyc + (legal ? 3 : 1)
      });
      if (legal) rd_q.push_back('{addr: a, due: cyc + 1});
    end
    if (!keep) begin
      @(posedge clk);
      #1;
      arvalid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !in_flight) break;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic b_read(input logic [3:0] a,
                        input logic [1:0] e_resp,
                        input logic [31:0] e_data,
                        input int e_lat,
                        input int e_rd);
    bit ok;
    bit got;
    int hs;
    int nrd;
    ok  = 0;
    got = 0;
    hs  = 0;
    nrd = 0;
    @(posedge clk);
    #1;
    b_araddr  = a;
    b_arvalid = 1'b1;
    b_rready  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_arready) begin
        ok = 1;
        hs = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    b_arvalid = 1'b0;
    for (int i = 0; i < 10 && ok; i++) begin
      @(negedge clk);
      if (b_rd_en) begin
        nrd++;
        chk("b_rd_addr", 32'(b_rd_addr), 32'(a));
      end
      if (b_rvalid) begin
        got = 1;
        chk("b_latency", cyc - hs, e_lat);
        chk("b_rdata", b_rdata, e_data);
        chk("b_rresp", 32'(b_rresp), 32'(e_resp));
        break;
      end
    end
    chk("b_response", 32'(got), 32'd1);
    chk("b_rd_en_count", nrd, e_rd);
    @(posedge clk);
    #1;
    b_rready = 1'b0;
  endtask

  initial begin
    logic [3:0] a;
    int         rv;
    for (int i = 0; i < NR; i++) mem[i] = $urandom;
    mem[1] = 32'hDEADBEEF;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;

    issue(4'h4, 1, 0);
    issue(4'h2, 1, 0);
    drain();

    bp_req = 1;
    issue(4'h8, 1, 0);
    drain();
    chk("bp_applied", 32'(bp_req), 32'd0);

    issue(4'h0, 1, 1);
    issue(4'hC, 1, 0);
    drain();

    repeat (150) begin
      if ($urandom_range(0, 4) < 3) a = 4'($urandom_range(0, 3) * 4);
      else a = 4'($urandom_range(0, 15));
      issue(a, 1, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();

    mon_en = 0;
    @(posedge clk);
    #1;
    rready = 1'b0;
    issue(4'h4, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid) break;
    end
    chk("pre_reset_rvalid", 32'(rvalid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd1);
    chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1;
    rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid) rv++;
    end
    chk("no_resp_after_rst", rv, 0);
    issue(4'h8, 1, 0);
    drain();

    b_read(4'h8, 2'b10, 32'h0, 1, 0);
    b_read(4'h4, 2'b00, 32'h1234_5678, 3, 1);

    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
